// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch controller slice:
//   - sw_state_t      : controller state enumeration (IDLE, RUN, PAUSE, LAP)
//   - default field limits and their BCD digit limits
//   - tens_digit/ones_digit helpers used to split a field limit
//     (e.g. SEC_MAX) into its per-digit limits
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned SEC_MAX_DEF = 59;
    localparam int unsigned MIN_MAX_DEF = 59;

    function automatic logic [3:0] tens_digit(input int unsigned v);
        return 4'((v / 10) % 10);
    endfunction

    function automatic logic [3:0] ones_digit(input int unsigned v);
        return 4'(v % 10);
    endfunction

    localparam logic [3:0] SEC_T_MAX_DEF = tens_digit(SEC_MAX_DEF);
    localparam logic [3:0] SEC_O_MAX_DEF = ones_digit(SEC_MAX_DEF);
    localparam logic [3:0] MIN_T_MAX_DEF = tens_digit(MIN_MAX_DEF);
    localparam logic [3:0] MIN_O_MAX_DEF = ones_digit(MIN_MAX_DEF);

endpackage

// File: rtl/stopwatch_ctrl_bcd_mmss_counter.sv
// bcd_mmss_counter
// Live MM:SS count held as four BCD digits with ripple carry.
// Ports:
//   clk                        : clock
//   srst                       : synchronous active-high reset, clears to 00:00
//   inc                        : advance by one second on this edge
//   clr                        : clear to 00:00 on this edge (wins over inc)
//   min_t, min_o, sec_t, sec_o : current count digits
module bcd_mmss_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_MAX = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX = MIN_MAX_DEF
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o
);

    localparam logic [3:0] SEC_T_MAX = tens_digit(SEC_MAX);
    localparam logic [3:0] SEC_O_MAX = ones_digit(SEC_MAX);
    localparam logic [3:0] MIN_T_MAX = tens_digit(MIN_MAX);
    localparam logic [3:0] MIN_O_MAX = ones_digit(MIN_MAX);

    logic [3:0] min_t_reg, min_o_reg, sec_t_reg, sec_o_reg;

    // A field wraps when it equals its limit as a whole; otherwise the ones
    // digit wraps at 9 and carries into the tens digit. This keeps every
    // digit in 0..9 and the field within its limit.
    logic sec_at_max, min_at_max;
    assign sec_at_max = (sec_t_reg == SEC_T_MAX) && (sec_o_reg == SEC_O_MAX);
    assign min_at_max = (min_t_reg == MIN_T_MAX) && (min_o_reg == MIN_O_MAX);

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            min_t_reg <= 4'd0;
            min_o_reg <= 4'd0;
            sec_t_reg <= 4'd0;
            sec_o_reg <= 4'd0;
        end else if (inc) begin
            if (sec_at_max) begin
                sec_t_reg <= 4'd0;
                sec_o_reg <= 4'd0;
                // Seconds rolled over: advance minutes, wrapping silently.
                if (min_at_max) begin
                    min_t_reg <= 4'd0;
                    min_o_reg <= 4'd0;
                end else if (min_o_reg == 4'd9) begin
                    min_o_reg <= 4'd0;
                    min_t_reg <= min_t_reg + 4'd1;
                end else begin
                    min_o_reg <= min_o_reg + 4'd1;
                end
            end else if (sec_o_reg == 4'd9) begin
                sec_o_reg <= 4'd0;
                sec_t_reg <= sec_t_reg + 4'd1;
            end else begin
                sec_o_reg <= sec_o_reg + 4'd1;
            end
        end
    end

    assign min_t = min_t_reg;
    assign min_o = min_o_reg;
    assign sec_t = sec_t_reg;
    assign sec_o = sec_o_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Start/stop/lap stopwatch controller with MM:SS BCD display.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   tick       : 1 Hz count enable, one cycle wide
//   stop       : start/stop toggle request (wins over lap)
//   lap        : lap freeze/release, or clear when paused
//   min_t..sec_o : displayed BCD digits (snapshot in LAP, live otherwise)
//   running    : state is RUN or LAP
//   lap_active : state is LAP (display frozen)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_MAX = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX = MIN_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       stop,
    input  logic       lap,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       lap_active
);

    sw_state_t  state_reg;
    logic       running_reg;
    logic       lap_active_reg;

    // Digit order everywhere: [3]=min_t, [2]=min_o, [1]=sec_t, [0]=sec_o.
    logic [3:0] live_dig [4];
    logic [3:0] snap_reg [4];
    logic [3:0] disp_dig [4];

    logic count_inc;
    logic count_clr;
    logic snap_take;

    // All qualifiers look at the registered state, so a tick arriving with a
    // transition is judged by the state before that transition.
    assign count_inc = tick && ((state_reg == ST_RUN) || (state_reg == ST_LAP));
    assign count_clr = (state_reg == ST_PAUSE) && lap && !stop;
    assign snap_take = (state_reg == ST_RUN) && lap && !stop;

    bcd_mmss_counter #(
        .SEC_MAX (SEC_MAX),
        .MIN_MAX (MIN_MAX)
    ) u_live (
        .clk   (clk),
        .srst  (reset),
        .inc   (count_inc),
        .clr   (count_clr),
        .min_t (live_dig[3]),
        .min_o (live_dig[2]),
        .sec_t (live_dig[1]),
        .sec_o (live_dig[0])
    );

    // Flags are written together with the state so they always equal a
    // decode of the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            running_reg    <= 1'b0;
            lap_active_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (stop) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_reg   <= ST_PAUSE;
                        running_reg <= 1'b0;
                    end else if (lap) begin
                        state_reg      <= ST_LAP;
                        lap_active_reg <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (stop) begin
                        state_reg      <= ST_PAUSE;
                        running_reg    <= 1'b0;
                        lap_active_reg <= 1'b0;
                    end else if (lap) begin
                        state_reg      <= ST_RUN;
                        lap_active_reg <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end else if (lap) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    running_reg    <= 1'b0;
                    lap_active_reg <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot copies the live value present before this edge's increment.
    always_ff @(posedge clk) begin
        if (reset || count_clr) begin
            for (int i = 0; i < 4; i++) snap_reg[i] <= 4'd0;
        end else if (snap_take) begin
            for (int i = 0; i < 4; i++) snap_reg[i] <= live_dig[i];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_disp
            assign disp_dig[gi] = lap_active_reg ? snap_reg[gi] : live_dig[gi];
        end
    endgenerate

    assign min_t      = disp_dig[3];
    assign min_o      = disp_dig[2];
    assign sec_t      = disp_dig[1];
    assign sec_o      = disp_dig[0];
    assign running    = running_reg;
    assign lap_active = lap_active_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       stop = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       running, lap_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.SEC_MAX(59), .MIN_MAX(59)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .stop       (stop),
        .lap        (lap),
        .min_t      (min_t),
        .min_o      (min_o),
        .sec_t      (sec_t),
        .sec_o      (sec_o),
        .running    (running),
        .lap_active (lap_active)
    );

    typedef struct {
        logic        r;
        logic        t;
        logic        s;
        logic        l;
        logic [15:0] disp;
        logic        run;
        logic        lapa;
    } vec_t;

    vec_t vecs [21];

    // One clock cycle: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic r, input logic t, input logic s, input logic l);
        reset = r; tick = t; stop = s; lap = l;
        @(posedge clk);
        #1;
        reset = 1'b0; tick = 1'b0; stop = 1'b0; lap = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] disp,
                         input logic run, input logic lapa);
        logic [15:0] act;
        act = {min_t, min_o, sec_t, sec_o};
        checks++;
        if (act !== disp || running !== run || lap_active !== lapa) begin
            errors++;
            $display("FAIL %s: got %h run=%b lap=%b, expected %h run=%b lap=%b",
                     name, act, running, lap_active, disp, run, lapa);
        end else begin
            $display("ok   %s: %h run=%b lap=%b", name, act, running, lap_active);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        //          r     t     s     l     disp      run   lap
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // reset wins
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}; // lap ignored in IDLE
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // no count in IDLE
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}; // -> RUN
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0}; // stop+tick counts
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0}; // paused
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}; // -> IDLE clear
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}; // -> RUN
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1}; // lap+tick: pre-inc snap
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1}; // frozen, live=3
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0}; // LAP->PAUSE live shown
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0}; // -> RUN
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0}; // stop+lap -> PAUSE
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0}; // -> RUN
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1}; // -> LAP
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0}; // -> RUN
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // reset

        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].l);
            check($sformatf("vec%0d", i), vecs[i].disp, vecs[i].run, vecs[i].lapa);
        end

        // 75 ticks from start -> 01:15
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        ticks(10);
        check("run_10", 16'h0010, 1'b1, 1'b0);
        ticks(65);
        check("run_75", 16'h0115, 1'b1, 1'b0);

        // Lap freeze at 00:10, 5 ticks, release -> 00:15
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        ticks(10);
        step(0, 0, 0, 1);
        check("lap_enter", 16'h0010, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            check($sformatf("lap_hold%0d", i), 16'h0010, 1'b1, 1'b1);
        end
        step(0, 0, 0, 1);
        check("lap_release", 16'h0015, 1'b1, 1'b0);

        // Count to 59:58, then wrap through 59:59 to 00:00
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        ticks(3598);
        check("near_end", 16'h5958, 1'b1, 1'b0);
        ticks(1);
        check("at_max", 16'h5959, 1'b1, 1'b0);
        ticks(1);
        check("wrap", 16'h0000, 1'b1, 1'b0);
        ticks(1);
        check("after_wrap", 16'h0001, 1'b1, 1'b0);

        // Stop and tick together at 00:03, then clear
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        ticks(3);
        step(0, 1, 1, 0);
        check("stop_tick", 16'h0004, 1'b0, 1'b0);
        step(0, 0, 0, 1);
        check("pause_clear", 16'h0000, 1'b0, 1'b0);
        step(0, 1, 0, 0);
        check("idle_no_count", 16'h0000, 1'b0, 1'b0);

        // Reset in LAP together with tick
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        ticks(4);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        check("lap_before_reset", 16'h0004, 1'b1, 1'b1);
        step(1, 1, 0, 0);
        check("reset_in_lap", 16'h0000, 1'b0, 1'b0);
        step(0, 0, 1, 0);
        check("restart_after_reset", 16'h0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: SEC_MAX, default 59, last seconds value before the seconds field wraps.
REQ-002 Parameter: MIN_MAX, default 59, last minutes value before the minutes field wraps.
REQ-003 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: tick  input  1  count enable, 1 Hz, one clk cycle wide.
REQ-006 Port: stop  input  1  start/stop toggle request, one clk cycle wide, already debounced.
REQ-007 Port: lap  input  1  lap/clear request, one clk cycle wide, already debounced.
REQ-008 Port: min_t  output  4  displayed minutes tens digit, BCD.
REQ-009 Port: min_o  output  4  displayed minutes ones digit, BCD.
REQ-010 Port: sec_t  output  4  displayed seconds tens digit, BCD.
REQ-011 Port: sec_o  output  4  displayed seconds ones digit, BCD.
REQ-012 Port: running  output  1  high while the state is RUN or LAP.
REQ-013 Port: lap_active  output  1  high while the state is LAP, meaning the display is frozen.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, PAUSE and LAP.
REQ-015 IDLE: stop -> RUN; lap is ignored.
REQ-016 RUN: stop -> PAUSE; lap -> LAP and the snapshot register captures the live count.
REQ-017 LAP: stop -> PAUSE; lap -> RUN.
REQ-018 PAUSE: stop -> RUN; lap -> IDLE and both the live count and the snapshot are cleared to 00:00.
REQ-019 When stop and lap are high in the same cycle, stop SHALL win and lap SHALL be discarded.
REQ-020 The live count SHALL increment by one second on a cycle where tick=1 and the current, registered state is RUN or LAP; the increment SHALL be visible one edge later.
REQ-021 A tick arriving in the same cycle as a transition SHALL be qualified by the pre-transition state, e.g. tick and stop in RUN still counts.
REQ-022 The snapshot taken on RUN->LAP SHALL hold the pre-increment live value when tick coincides with lap.
REQ-023 Counting SHALL be BCD ripple: sec_o 9->0 carries into sec_t; sec_t at SEC_MAX/10 with sec_o=9 -> 0 carries into minutes; minutes follow the same scheme up to MIN_MAX.
REQ-024 The count SHALL wrap from MIN_MAX:SEC_MAX, i.e. 59:59, to 00:00 on the next qualified tick, keep counting, and flag nothing.
REQ-025 No BCD digit SHALL ever exceed 9, and the seconds field SHALL never exceed SEC_MAX.
REQ-026 Display outputs SHALL show the snapshot in LAP and the live count in all other states, selected combinationally from registers with no extra latency.
REQ-027 After LAP->PAUSE the display SHALL immediately show the live count.
REQ-028 running and lap_active SHALL be decoded from the state register only.

Reset
REQ-029 reset=1 at a rising edge SHALL set state=IDLE, live count=00:00, snapshot=00:00, running=0 and lap_active=0.
REQ-030 Reset SHALL take priority over tick, stop and lap in the same cycle.
REQ-031 Reset asserted mid-count, in RUN or LAP, SHALL abort with no residual snapshot.
REQ-032 Outputs SHALL be undefined-free from the first edge with reset high.

Structure
REQ-033 A shared package stopwatch_pkg SHALL hold the state enumeration and the BCD digit limit constants derived from SEC_MAX and MIN_MAX.
REQ-034 A single sub-module bcd_mmss_counter (inputs: inc, clr; outputs: four digits) SHALL implement the live count.
REQ-035 The snapshot register and the FSM SHALL reside in stopwatch_ctrl.

Verification
REQ-036 Reset, then stop, then 75 ticks -> display 01:15, running=1.
REQ-037 At 00:10 in RUN, lap, then 5 ticks -> display stays 00:10 with lap_active=1; then lap -> display 00:15.
REQ-038 Preload near the end, count to 59:58, then 2 ticks -> display 00:00, running=1.
REQ-039 In RUN at 00:03, stop and tick in the same cycle -> state PAUSE, display 00:04; then lap -> IDLE, 00:00.
REQ-040 stop and lap together in RUN -> PAUSE with no snapshot taken; reset asserted in LAP together with tick -> IDLE, 00:00, all flags 0.
